// File: rtl/fx_reg_slave.sv
// fx-bus slave responder: address decode, control/config register bank and registered read data.
// Optional build macro FX_SLAVE_SHADOW_EN stages CFG writes in shadows applied by CMD bit0.
module fx_reg_slave #(
  parameter logic [5:0] DEV_ID  = 6'h01,
  parameter logic [7:0] VERSION = 8'h10
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        fx_wr,
  input  logic [7:0]  fx_data,
  input  logic [21:0] fx_waddr,
  input  logic        fx_rd,
  input  logic [21:0] fx_raddr,
  output logic [7:0]  fx_q,
  input  logic [7:0]  status_in,
  output logic [7:0]  ctrl,
  output logic [7:0]  cfg0,
  output logic [7:0]  cfg1,
  output logic [7:0]  cfg2,
  output logic [7:0]  cfg3,
  output logic [7:0]  cmd_pulse
);

  localparam logic [7:0] OFF_ID     = 8'h00;
  localparam logic [7:0] OFF_VER    = 8'h01;
  localparam logic [7:0] OFF_CTRL   = 8'h02;
  localparam logic [7:0] OFF_CMD    = 8'h03;
  localparam logic [7:0] OFF_CFG0   = 8'h04;
  localparam logic [7:0] OFF_CFG1   = 8'h05;
  localparam logic [7:0] OFF_CFG2   = 8'h06;
  localparam logic [7:0] OFF_CFG3   = 8'h07;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_WRCNT  = 8'h09;
  localparam logic [7:0] OFF_ERRCNT = 8'h0A;

  logic [7:0]      ctrl_q, ctrl_d;
  logic [7:0]      cmd_pulse_q, cmd_pulse_d;
  logic [7:0]      wrcnt_q, wrcnt_d;
  logic [7:0]      errcnt_q, errcnt_d;
  logic [7:0]      fx_q_q, fx_q_d;
  logic [3:0][7:0] cfg_q, cfg_d;
  logic [3:0][7:0] cfg_view;
`ifdef FX_SLAVE_SHADOW_EN
  logic [3:0][7:0] shadow_q, shadow_d;
`endif

  logic       wr_hit, rd_hit;
  logic [7:0] wr_off, rd_off;
  logic       wr_rw, wr_cmd, wr_err, rd_err;
  logic       cnt_clear, cfg_wr;
  logic [7:0] rd_data;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign wr_off = fx_waddr[7:0];
  assign rd_off = fx_raddr[7:0];
  assign wr_hit = fx_wr && (fx_waddr[21:16] == DEV_ID) && (fx_waddr[15:8] == 8'h00);
  assign rd_hit = fx_rd && (fx_raddr[21:16] == DEV_ID) && (fx_raddr[15:8] == 8'h00);

`ifdef FX_SLAVE_SHADOW_EN
  assign cfg_view = shadow_q;
`else
  assign cfg_view = cfg_q;
`endif

  // Classify a hit write as register update, command, or error
  always_comb begin
    wr_rw  = 1'b0;
    wr_cmd = 1'b0;
    wr_err = 1'b0;
    if (wr_hit) begin
      case (wr_off)
        OFF_CTRL, OFF_CFG0, OFF_CFG1, OFF_CFG2, OFF_CFG3: wr_rw  = 1'b1;
        OFF_CMD:                                          wr_cmd = 1'b1;
        default:                                          wr_err = 1'b1;
      endcase
    end else begin
      wr_rw  = 1'b0;
    end
  end

  // Read mux: all sources are pre-write values so a same-cycle write is not seen
  always_comb begin
    rd_data = 8'h00;
    rd_err  = 1'b0;
    if (rd_hit) begin
      case (rd_off)
        OFF_ID:     rd_data = {2'b00, DEV_ID};
        OFF_VER:    rd_data = VERSION;
        OFF_CTRL:   rd_data = ctrl_q;
        OFF_CMD:    rd_data = 8'h00;
        OFF_CFG0:   rd_data = cfg_view[0];
        OFF_CFG1:   rd_data = cfg_view[1];
        OFF_CFG2:   rd_data = cfg_view[2];
        OFF_CFG3:   rd_data = cfg_view[3];
        OFF_STATUS: rd_data = status_in;
        OFF_WRCNT:  rd_data = wrcnt_q;
        OFF_ERRCNT: rd_data = errcnt_q;
        default: begin
          rd_data = 8'h00;
          rd_err  = 1'b1;
        end
      endcase
    end else begin
      rd_data = 8'h00;
    end
  end

  assign cnt_clear = wr_cmd && fx_data[7];
  assign cfg_wr    = wr_rw && (wr_off[7:2] == 6'h01);
  assign err_inc   = {1'b0, wr_err} + {1'b0, rd_err};
  assign err_sum   = {1'b0, errcnt_q} + {7'h00, err_inc};

  // Next-state for counters, control, command pulse and read data
  always_comb begin
    ctrl_d      = ctrl_q;
    wrcnt_d     = wrcnt_q;
    errcnt_d    = errcnt_q;
    cmd_pulse_d = wr_cmd ? fx_data : 8'h00;
    fx_q_d      = rd_data;

    if (wr_rw && (wr_off == OFF_CTRL)) begin
      ctrl_d = fx_data;
    end else begin
      ctrl_d = ctrl_q;
    end

    // A clearing CMD write wins over any count event in the same cycle
    if (cnt_clear) begin
      wrcnt_d  = 8'h00;
      errcnt_d = 8'h00;
    end else begin
      if (wr_rw || wr_cmd) begin
        wrcnt_d = wrcnt_q + 8'h01;
      end else begin
        wrcnt_d = wrcnt_q;
      end
      if (err_sum[8]) begin
        errcnt_d = 8'hFF;
      end else begin
        errcnt_d = err_sum[7:0];
      end
    end
  end

`ifdef FX_SLAVE_SHADOW_EN
  // Shadows take CFG writes; the live set loads from pre-write shadows on apply
  always_comb begin
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    if (cfg_wr) begin
      shadow_d[wr_off[1:0]] = fx_data;
    end else begin
      shadow_d = shadow_q;
    end
    if (wr_cmd && fx_data[0]) begin
      cfg_d = shadow_q;
    end else begin
      cfg_d = cfg_q;
    end
  end
`else
  // CFG writes land directly in the live registers
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_wr) begin
      cfg_d[wr_off[1:0]] = fx_data;
    end else begin
      cfg_d = cfg_q;
    end
  end
`endif

  // State registers with synchronous reset
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ctrl_q      <= 8'h00;
      cmd_pulse_q <= 8'h00;
      wrcnt_q     <= 8'h00;
      errcnt_q    <= 8'h00;
      fx_q_q      <= 8'h00;
      cfg_q       <= {4{8'h00}};
`ifdef FX_SLAVE_SHADOW_EN
      shadow_q    <= {4{8'h00}};
`endif
    end else begin
      ctrl_q      <= ctrl_d;
      cmd_pulse_q <= cmd_pulse_d;
      wrcnt_q     <= wrcnt_d;
      errcnt_q    <= errcnt_d;
      fx_q_q      <= fx_q_d;
      cfg_q       <= cfg_d;
`ifdef FX_SLAVE_SHADOW_EN
      shadow_q    <= shadow_d;
`endif
    end
  end

  assign fx_q      = fx_q_q;
  assign ctrl      = ctrl_q;
  assign cmd_pulse = cmd_pulse_q;
  assign cfg0      = cfg_q[0];
  assign cfg1      = cfg_q[1];
  assign cfg2      = cfg_q[2];
  assign cfg3      = cfg_q[3];

endmodule

// File: tb/tb_fx_reg_slave.sv
// Directed bench for fx_reg_slave: stimulus queues expected read data, a monitor checks fx_q every cycle.
module tb_fx_reg_slave;

  localparam logic [5:0] DEV = 6'h05;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        fx_wr = 1'b0;
  logic [7:0]  fx_data = 8'h00;
  logic [21:0] fx_waddr = 22'h0;
  logic        fx_rd = 1'b0;
  logic [21:0] fx_raddr = 22'h0;
  logic [7:0]  fx_q;
  logic [7:0]  status_in = 8'h00;
  logic [7:0]  ctrl, cfg0, cfg1, cfg2, cfg3, cmd_pulse;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic rd_seen = 1'b0;

  fx_reg_slave #(.DEV_ID(DEV), .VERSION(8'h10)) dut (
    .clk_sys(clk_sys), .rst(rst), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_waddr(fx_waddr), .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .status_in(status_in), .ctrl(ctrl), .cfg0(cfg0), .cfg1(cfg1),
    .cfg2(cfg2), .cfg3(cfg3), .cmd_pulse(cmd_pulse)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_sys) rd_seen <= fx_rd;

  always @(negedge clk_sys) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fx_q_unexpected: got 0x%02h with no queued expectation", fx_q);
      end else begin
        chk("fx_q", fx_q, exp_q.pop_front());
      end
    end else begin
      chk("fx_q_idle", fx_q, 8'h00);
    end
  end

  function automatic logic [21:0] adr(input logic [5:0] id, input logic [7:0] off);
    return {id, 8'h00, off};
  endfunction

  task automatic cyc(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                     input logic rd, input logic [21:0] ra, input logic [7:0] exp);
    fx_wr = wr; fx_waddr = wa; fx_data = wd;
    fx_rd = rd; fx_raddr = ra;
    if (rd) exp_q.push_back(exp);
    @(posedge clk_sys); #1;
    fx_wr = 1'b0; fx_rd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    cyc(1'b1, adr(DEV, off), d, 1'b0, 22'h0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] off, input logic [7:0] exp);
    cyc(1'b0, 22'h0, 8'h00, 1'b1, adr(DEV, off), exp);
  endtask

  task automatic idle();
    cyc(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    rst = 1'b0;
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_cfg0", cfg0, 8'h00);
    chk("rst_cfg3", cfg3, 8'h00);
    chk("rst_cmd_pulse", cmd_pulse, 8'h00);

    // ID and VERSION with a gap between
    rd(8'h00, 8'h05);
    idle();
    rd(8'h01, 8'h10);
    idle();

    // CTRL write then read back and count
    wr(8'h02, 8'hA5);
    chk("ctrl_after_wr", ctrl, 8'hA5);
    rd(8'h02, 8'hA5);
    rd(8'h09, 8'h01);

    // Misses on device id and on nonzero bits [15:8]
    cyc(1'b1, adr(6'h06, 8'h02), 8'h3C, 1'b0, 22'h0, 8'h00);
    cyc(1'b0, 22'h0, 8'h00, 1'b1, adr(6'h06, 8'h02), 8'h00);
    cyc(1'b1, {DEV, 8'h01, 8'h02}, 8'h3C, 1'b0, 22'h0, 8'h00);
    cyc(1'b0, 22'h0, 8'h00, 1'b1, {DEV, 8'h01, 8'h00}, 8'h00);
    chk("ctrl_after_miss", ctrl, 8'hA5);
    rd(8'h09, 8'h01);
    rd(8'h0A, 8'h00);

    // Error counting, then clear by CMD bit7
    wr(8'h08, 8'h33);
    rd(8'h20, 8'h00);
    rd(8'h0A, 8'h02);
    rd(8'h09, 8'h01);
    wr(8'h03, 8'h80);
    chk("cmd_pulse_80", cmd_pulse, 8'h80);
    idle();
    chk("cmd_pulse_drop", cmd_pulse, 8'h00);
    rd(8'h09, 8'h00);
    rd(8'h0A, 8'h00);

    // Same-cycle write and read of CFG0 returns the old value
    wr(8'h04, 8'h11);
    cyc(1'b1, adr(DEV, 8'h04), 8'h5A, 1'b1, adr(DEV, 8'h04), 8'h11);
    rd(8'h04, 8'h5A);
`ifdef FX_SLAVE_SHADOW_EN
    chk("cfg0_staged", cfg0, 8'h00);
`else
    chk("cfg0_direct", cfg0, 8'h5A);
`endif

    // CFG1 write and apply
    wr(8'h05, 8'h77);
`ifdef FX_SLAVE_SHADOW_EN
    chk("cfg1_staged", cfg1, 8'h00);
`else
    chk("cfg1_direct", cfg1, 8'h77);
`endif
    rd(8'h05, 8'h77);
    wr(8'h03, 8'h01);
    chk("cfg1_applied", cfg1, 8'h77);
    chk("cfg0_applied", cfg0, 8'h5A);
    chk("cmd_pulse_01", cmd_pulse, 8'h01);
    rd(8'h09, 8'h04);

    // CMD reads zero, STATUS sampled at read edge
    rd(8'h03, 8'h00);
    status_in = 8'h9C;
    rd(8'h08, 8'h9C);
    status_in = 8'h00;
    rd(8'h0A, 8'h00);

    // Back-to-back reads
    rd(8'h00, 8'h05);
    rd(8'h01, 8'h10);
    rd(8'h02, 8'hA5);
    idle();

    // ERRCNT saturation, then clear winning over a same-cycle error read
    for (int i = 0; i < 257; i++) rd(8'h30, 8'h00);
    rd(8'h0A, 8'hFF);
    cyc(1'b1, adr(DEV, 8'h03), 8'h80, 1'b1, adr(DEV, 8'h30), 8'h00);
    rd(8'h0A, 8'h00);
    rd(8'h09, 8'h00);

    // WRCNT wrap
    for (int i = 0; i < 255; i++) wr(8'h02, 8'(i));
    rd(8'h09, 8'hFF);
    wr(8'h02, 8'hC3);
    rd(8'h09, 8'h00);
    chk("ctrl_last", ctrl, 8'hC3);

    // Read coinciding with reset returns zero, state cleared
    rst = 1'b1;
    rd(8'h00, 8'h00);
    rst = 1'b0;
    chk("rst2_ctrl", ctrl, 8'h00);
    chk("rst2_cfg1", cfg1, 8'h00);
    rd(8'h09, 8'h00);
    rd(8'h05, 8'h00);
    idle();
    idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
